// File: rtl/nibble_serial_adder16_pkg.sv
// nibble_serial_adder16_pkg: shared state encodings and default operand/slice widths
package nibble_serial_adder16_pkg;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/nibble_serial_adder16_if.sv
// nibble_serial_adder16_if: start/done request bus between requester (master) and adder (slave)
// Ports: start, in_a, in_b, cin from master; busy, done, sum, cout from slave.
interface nibble_serial_adder16_if
  import nibble_serial_adder16_pkg::*;
#(
  parameter int W = WIDTH
);
  logic start, cin, busy, done, cout;
  logic [W-1:0] in_a, in_b, sum;
  modport master(output start, in_a, in_b, cin, input busy, done, sum, cout);
  modport slave(input start, in_a, in_b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/nibble_serial_adder16_rca_slice.sv
// nibble_serial_adder16_rca_slice: combinational S-bit ripple-carry adder built from full adders
// Ports: a, b (S bits), ci in; s (S bits), co out.
module nibble_serial_adder16_rca_slice #(
  parameter int S = 4
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         ci,
  output logic [S-1:0] s,
  output logic         co
);
  logic [S:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < S; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[S];
endmodule

// File: rtl/nibble_serial_adder16.sv
// nibble_serial_adder16: slice-serial W-bit adder reusing one S-bit ripple slice over W/S cycles
// Ports: clk; rst (async, active-low); bus (slave): start/in_a/in_b/cin in, busy/done/sum/cout out.
module nibble_serial_adder16
  import nibble_serial_adder16_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int S = SLICE
) (
  input logic clk,
  input logic rst,
  nibble_serial_adder16_if.slave bus
);
  localparam int N = W / S;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_q, b_q, acc, acc_n, sum_q;
  logic [S-1:0] s;
  logic carry_q, cout_q, co, accept, last;
  // start is only honoured outside CALC, so in-flight operands are never overwritten
  assign accept = bus.start && state != ST_CALC;
  assign last = state == ST_CALC && cnt == LAST;
  nibble_serial_adder16_rca_slice #(.S(S)) u_slice (
    .a (a_q[cnt*S +: S]),
    .b (b_q[cnt*S +: S]),
    .ci(carry_q),
    .s (s),
    .co(co)
  );
  always_comb begin
    acc_n = acc;
    acc_n[cnt*S +: S] = s;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = ST_CALC;
    else if (last) state_n = ST_DONE;
    else if (state == ST_DONE) state_n = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else state <= state_n;
  end
  // Slices accumulate privately; sum/cout only change on the edge entering DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      carry_q <= bus.cin;
      cnt     <= '0;
    end else if (state == ST_CALC) begin
      acc     <= acc_n;
      carry_q <= co;
      cnt     <= last ? cnt : cnt + 1'b1;
      if (last) begin
        sum_q  <= acc_n;
        cout_q <= co;
      end
    end
  end
  assign bus.busy = state == ST_CALC;
  assign bus.done = state == ST_DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder16.sv
// tb_nibble_serial_adder16: directed self-checking bench for the slice-serial adder
module tb_nibble_serial_adder16;
  import nibble_serial_adder16_pkg::*;
  localparam int N = WIDTH / SLICE;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int errs = 0;
  int cyc, gap, ndone;
  always #5 clk = ~clk;
  nibble_serial_adder16_if #(.W(WIDTH)) bus ();
  nibble_serial_adder16 #(.W(WIDTH), .S(SLICE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [16:0] exp);
    int n;
    start_op(a, b, c);
    wait_done(n);
    chk(tag, 32'({bus.cout, bus.sum}), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.cin   = 1'b0;
    #20;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'({bus.cout, bus.sum}), 32'h0);
    rst = 1'b1;
    count_done(10, ndone);
    chk("idle_no_done", 32'(ndone), 32'd0);
    // basic add, with busy visible right after acceptance
    start_op(16'h1234, 16'h4321, 1'b1);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done(cyc);
    chk("basic", 32'({bus.cout, bus.sum}), 32'h05556);
    @(negedge clk);
    chk("basic_pulse", 32'(bus.done), 32'd0);
    op("corner_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    op("corner_max", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    // start re-pulse during CALC is ignored
    start_op(16'h00FF, 16'h0001, 1'b0);
    bus.start = 1'b1;
    bus.in_a  = 16'h0001;
    bus.in_b  = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("ignore_restart", 32'({bus.cout, bus.sum}), 32'h00100);
    count_done(10, ndone);
    chk("no_extra_done", 32'(ndone), 32'd0);
    // back-to-back with start held; operands change right after acceptance
    bus.start = 1'b1;
    bus.in_a  = 16'h8000;
    bus.in_b  = 16'h8000;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.in_a  = 16'h0F0F;
    bus.in_b  = 16'hF0F0;
    bus.cin   = 1'b1;
    wait_done(cyc);
    chk("b2b_first", 32'({bus.cout, bus.sum}), 32'h10000);
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.done) begin
        gap = i;
        break;
      end
    end
    chk("b2b_gap", 32'(gap), 32'(N + 1));
    chk("b2b_second", 32'({bus.cout, bus.sum}), 32'h10000);
    @(negedge clk);
    chk("b2b_pulse", 32'(bus.done), 32'd0);
    // async reset in the middle of a computation
    op("pre_abort", 16'h0001, 16'h0002, 1'b0, 17'h00003);
    start_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'({bus.cout, bus.sum}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    count_done(10, ndone);
    chk("abort_no_done", 32'(ndone), 32'd0);
    op("after_abort", 16'hABCD, 16'h1111, 1'b0, 17'h0BCDE);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
